// File: rtl/instr_fetch_if.sv
// Program-load and fetch-output bundle shared by the instruction fetch block
// and whatever drives it (loader / control unit).
interface instr_fetch_if #(
  parameter int INSTR_WIDTH = 20,
  parameter int ADDR_BITS   = 5
);
  logic                   prog_we;
  logic [ADDR_BITS-1:0]   prog_addr;
  logic [INSTR_WIDTH-1:0] prog_data;
  logic                   start;
  logic [INSTR_WIDTH-1:0] instr;
  logic [ADDR_BITS-1:0]   pc;
  logic                   busy;
  logic                   halted;

  modport master (
    output prog_we, prog_addr, prog_data, start,
    input  instr, pc, busy, halted
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start,
    output instr, pc, busy, halted
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: small program memory plus an IDLE/RUN/HALT sequencer
// that presents each instruction word for a type-dependent number of cycles.
module instr_fetch #(
  parameter int INSTR_WIDTH = 20,
  parameter int ADDR_BITS   = 5
) (
  input  logic         clk,
  input  logic         rst,
  instr_fetch_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [1:0]             state;
  logic [2:0]             count;
  logic [INSTR_WIDTH-1:0] instr_r;
  logic [ADDR_BITS-1:0]   pc_r;
  logic [ADDR_BITS-1:0]   pc_inc;
  logic [INSTR_WIDTH-1:0] first_word;
  logic [INSTR_WIDTH-1:0] next_word;

  // Number of cycles a word stays on instr; 0 marks the halt type.
  function automatic logic [2:0] hold_len(input logic [INSTR_WIDTH-1:0] w);
    case (w[INSTR_WIDTH-1 -: 2])
      2'b01:   hold_len = 3'd3;
      2'b10:   hold_len = 3'd4;
      2'b11:   hold_len = 3'd3;
      default: hold_len = 3'd0;
    endcase
  endfunction

  function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] w);
    is_halt = (w[INSTR_WIDTH-1 -: 2] == 2'b00);
  endfunction

  assign pc_inc    = pc_r + 1'b1;
  assign next_word = mem[pc_inc];
  // A load to address 0 on the start edge must be seen by that same fetch.
  assign first_word = (bus.prog_we && (bus.prog_addr == '0)) ? bus.prog_data : mem[0];

  assign bus.instr  = instr_r;
  assign bus.pc     = pc_r;
  assign bus.busy   = (state == S_RUN);
  assign bus.halted = (state == S_HALT);

  // Program memory: loadable only while idle, untouched by reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (state == S_IDLE))
      mem[bus.prog_addr] <= bus.prog_data;
  end

  // Sequencer: start fetch, hold countdown, advance/wrap, halt detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      instr_r <= '0;
      pc_r    <= '0;
      count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pc_r <= '0;
            if (is_halt(first_word)) begin
              state   <= S_HALT;
              instr_r <= '0;
              count   <= '0;
            end else begin
              // Extra cycle lets the control unit leave its reset state.
              state   <= S_RUN;
              instr_r <= first_word;
              count   <= hold_len(first_word) + 3'd1;
            end
          end
        end
        S_RUN: begin
          if (count > 3'd1) begin
            count <= count - 3'd1;
          end else begin
            pc_r <= pc_inc;
            if (is_halt(next_word)) begin
              state   <= S_HALT;
              instr_r <= '0;
              count   <= '0;
            end else begin
              instr_r <= next_word;
              count   <= hold_len(next_word);
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_if #(.INSTR_WIDTH(20), .ADDR_BITS(5)) bus ();

  instr_fetch #(.INSTR_WIDTH(20), .ADDR_BITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [19:0] ei, input logic [4:0] ep,
                           input logic eb, input logic eh);
    chk({tag, ".instr"},  {12'd0, bus.instr}, {12'd0, ei});
    chk({tag, ".pc"},     {27'd0, bus.pc},    {27'd0, ep});
    chk({tag, ".busy"},   {31'd0, bus.busy},  {31'd0, eb});
    chk({tag, ".halted"}, {31'd0, bus.halted}, {31'd0, eh});
  endtask

  task automatic prog(input logic [4:0] a, input logic [19:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.start     = 1'b0;

    // Reset state
    tick();
    tick();
    chk_state("reset", 20'h0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_state("idle_hold", 20'h0, 5'd0, 1'b0, 1'b0);

    // std_op then halt: 4 cycles of 0x40000, then HALT at pc 1
    prog(5'd0, 20'h40000);
    prog(5'd1, 20'h00000);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk_state($sformatf("std_hold%0d", i), 20'h40000, 5'd0, 1'b1, 1'b0);
      tick();
    end
    chk_state("std_halt", 20'h0, 5'd1, 1'b0, 1'b1);
    pulse_start();
    tick();
    chk_state("halt_ign_start", 20'h0, 5'd1, 1'b0, 1'b1);

    // loadR (5 cycles) then storeR (3 cycles) then HALT at pc 2
    do_reset();
    chk_state("rst_from_halt", 20'h0, 5'd0, 1'b0, 1'b0);
    prog(5'd0, 20'h80000);
    prog(5'd1, 20'hC0000);
    prog(5'd2, 20'h00000);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      chk_state($sformatf("ldr_hold%0d", i), 20'h80000, 5'd0, 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk_state($sformatf("str_hold%0d", i), 20'hC0000, 5'd1, 1'b1, 1'b0);
      tick();
    end
    chk_state("ldr_halt", 20'h0, 5'd2, 1'b0, 1'b1);

    // Reset mid-hold, then re-fetch from address 0 with memory intact
    do_reset();
    pulse_start();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_state("rst_mid_run", 20'h0, 5'd0, 1'b0, 1'b0);
    pulse_start();
    chk_state("refetch", 20'h80000, 5'd0, 1'b1, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_state("run_ign_start", 20'h80000, 5'd0, 1'b1, 1'b0);

    // Reset overrides start
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    chk_state("rst_over_start", 20'h0, 5'd0, 1'b0, 1'b0);

    // Halt word at address 0; writes and start in HALT ignored
    prog(5'd0, 20'h00000);
    pulse_start();
    chk_state("halt_first", 20'h0, 5'd0, 1'b0, 1'b1);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 5'd0;
    bus.prog_data = 20'h40000;
    bus.start     = 1'b1;
    tick();
    tick();
    bus.prog_we = 1'b0;
    bus.start   = 1'b0;
    chk_state("halt_ign_we", 20'h0, 5'd0, 1'b0, 1'b1);
    do_reset();
    pulse_start();
    chk_state("mem_unchanged", 20'h0, 5'd0, 1'b0, 1'b1);

    // Write to address 0 coincident with start is fetched on the same edge
    do_reset();
    bus.prog_we   = 1'b1;
    bus.prog_addr = 5'd0;
    bus.prog_data = 20'h40000;
    bus.start     = 1'b1;
    tick();
    bus.prog_we = 1'b0;
    bus.start   = 1'b0;
    chk_state("we_with_start", 20'h40000, 5'd0, 1'b1, 1'b0);

    // Full memory of std_op: first word 4 cycles, others 3, pc wraps 31->0
    do_reset();
    for (int a = 0; a < 32; a++) prog(a[4:0], 20'h40000);
    pulse_start();
    for (int c = 0; c < 100; c++) begin
      int exp_pc;
      exp_pc = (c < 4) ? 0 : (((c - 4) / 3) + 1) % 32;
      chk($sformatf("wrap_pc%0d", c), {27'd0, bus.pc}, exp_pc);
      chk($sformatf("wrap_halted%0d", c), {31'd0, bus.halted}, 32'd0);
      chk($sformatf("wrap_instr%0d", c), {12'd0, bus.instr}, 32'h40000);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
